hazard_scoreboard: RTL and testbench

- Parametrised hazard and flush controller for the in-order MIPS pipeline.
- Replaces the fixed load-use stall and control-stall logic.
- Tracks every in-flight instruction from EX to WB in an internal shift register of {valid, wr, rd, is_load}.
- Produces the ID stall, the bubble, hold and squash controls from that record, plus a stall performance counter.
- Supports both forwarding and non-forwarding datapaths, and a configurable branch-resolution stage.

---
 rtl/hazard_scoreboard_pkg.sv | 17 +
 rtl/hazard_scoreboard_if.sv | 40 ++++
 rtl/hazard_scoreboard_match.sv | 27 ++
 rtl/hazard_scoreboard.sv | 112 +++++++++++
 tb/tb_hazard_scoreboard.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the pipeline hazard/flush controller.
// The entry record is sized for the widest supported register address.
package hazard_scoreboard_pkg;

    localparam int DefRaddrW = 5;
    localparam int DefDepth  = 3;
    localparam int MaxRaddrW = 8;
    localparam int RegZero   = 0;

    typedef struct packed {
        logic                 valid;
        logic                 wr;
        logic                 isLoad;
        logic [MaxRaddrW-1:0] rd;
    } entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request and pipeline control bundle between the pipeline (master)
// and the hazard scoreboard (slave).
interface hazard_if
    import hazard_scoreboard_pkg::*;
#(
    parameter int RADDR_W = DefRaddrW,
    parameter int DEPTH   = DefDepth,
    parameter int CNT_W   = 32
);
    // id_valid qualifies the id_* fields; the ID instruction is accepted only in a
    // cycle where id_valid=1, hold_o=0 and redirect_i=0, otherwise it is not taken.
    logic               id_valid;
    logic [RADDR_W-1:0] id_rs;
    logic [RADDR_W-1:0] id_rt;
    logic               id_rs_used;
    logic               id_rt_used;
    logic               id_wr;
    logic [RADDR_W-1:0] id_rd;
    logic               id_is_load;
    logic               redirect_i;
    logic               stall_o;
    logic               hold_o;
    logic               bubble_o;
    logic               flush_ifid_o;
    logic [DEPTH-1:0]   squash_o;
    logic [CNT_W-1:0]   stall_cnt_o;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_wr, id_rd, id_is_load, redirect_i,
        input  stall_o, hold_o, bubble_o, flush_ifid_o, squash_o, stall_cnt_o
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_wr, id_rd, id_is_load, redirect_i,
        output stall_o, hold_o, bubble_o, flush_ifid_o, squash_o, stall_cnt_o
    );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// Compares one ID source register against every tracked in-flight entry.
// Register 0 and unused sources never match.
module hazard_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int RADDR_W = DefRaddrW,
    parameter int DEPTH   = DefDepth
) (
    input  logic               srcUsed,
    input  logic [RADDR_W-1:0] src,
    input  entry_t [DEPTH-1:0] entries,
    output logic [DEPTH-1:0]   match
);

    logic srcLive;

    assign srcLive = srcUsed && (src != RADDR_W'(RegZero));

    always_comb begin
        match = '0;
        for (int k = 0; k < DEPTH; k++) begin
            match[k] = srcLive && entries[k].valid && entries[k].wr &&
                       (entries[k].rd == MaxRaddrW'(src));
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and flush controller: tracks in-flight writers from EX to WB and
// derives the ID stall, hold, bubble, squash controls and a stall counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int RADDR_W        = DefRaddrW,
    parameter int DEPTH          = DefDepth,
    parameter int FWD_EN         = 1,
    parameter int RF_BYPASS      = 0,
    parameter int REDIRECT_STAGE = 1,
    parameter int CNT_W          = 32
) (
    input logic     clk,
    input logic     rst_n,
    hazard_if.slave bus
);

    localparam logic [DEPTH-1:0] RedirectSquash = DEPTH'((1 << REDIRECT_STAGE) - 1);

    entry_t [DEPTH-1:0] entries;
    entry_t             idEntry;
    logic [DEPTH-1:0]   rsMatch;
    logic [DEPTH-1:0]   rtMatch;
    logic [DEPTH-1:0]   stallMask;
    logic               hazard;
    logic               stall;
    logic               hold;
    logic               bubble;
    logic               flush;
    logic [DEPTH-1:0]   squash;
    logic               issue;
    logic [CNT_W-1:0]   stallCnt;

    hazard_match #(.RADDR_W(RADDR_W), .DEPTH(DEPTH)) uRsMatch (
        .srcUsed (bus.id_rs_used),
        .src     (bus.id_rs),
        .entries (entries),
        .match   (rsMatch)
    );

    hazard_match #(.RADDR_W(RADDR_W), .DEPTH(DEPTH)) uRtMatch (
        .srcUsed (bus.id_rt_used),
        .src     (bus.id_rt),
        .entries (entries),
        .match   (rtMatch)
    );

    // A stage is marked when its result cannot yet reach an ID read this cycle.
    always_comb begin
        stallMask = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (FWD_EN != 0) stallMask[k] = (k == 0) && entries[k].isLoad;
            else             stallMask[k] = (k < DEPTH - 1) || (RF_BYPASS == 0);
        end
    end

    assign hazard = |((rsMatch | rtMatch) & stallMask);
    assign stall  = bus.id_valid && hazard;
    assign issue  = bus.id_valid && !stall && !bus.redirect_i;

    always_comb begin
        hold   = stall;
        bubble = stall;
        flush  = 1'b0;
        squash = '0;
        if (bus.redirect_i) begin
            hold   = 1'b0;
            bubble = 1'b1;
            flush  = 1'b1;
            squash = RedirectSquash;
        end
    end

    always_comb begin
        idEntry = '0;
        if (issue) begin
            idEntry.valid  = 1'b1;
            idEntry.wr     = bus.id_wr && (bus.id_rd != RADDR_W'(RegZero));
            idEntry.isLoad = bus.id_is_load;
            idEntry.rd     = MaxRaddrW'(bus.id_rd);
        end
    end

    // Instructions younger than a resolving branch are dropped as they shift in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries <= '0;
        end else begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                entries[k] <= entries[k-1];
                if (bus.redirect_i && (k <= REDIRECT_STAGE)) entries[k].valid <= 1'b0;
            end
            entries[0] <= idEntry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt <= '0;
        end else if (hold && (stallCnt != '1)) begin
            stallCnt <= stallCnt + CNT_W'(1);
        end
    end

    assign bus.stall_o      = stall;
    assign bus.hold_o       = hold;
    assign bus.bubble_o     = bubble;
    assign bus.flush_ifid_o = flush;
    assign bus.squash_o     = squash;
    assign bus.stall_cnt_o  = stallCnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three configurations share one ID stimulus stream
// and are checked against an age-based model of in-flight register writers.
module tb_hazard_scoreboard;

    localparam int RW    = 5;
    localparam int DEPTH = 3;
    localparam int RS    = 1;
    localparam int W     = 16;
    localparam int NDUT  = 3;

    // One in-flight writer, tracked by how many edges ago it left ID.
    typedef struct {
        int         age;
        logic [4:0] rd;
        bit         load;
    } flight_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    hazard_if #(.RADDR_W(RW), .DEPTH(DEPTH), .CNT_W(8)) ifA ();
    hazard_if #(.RADDR_W(RW), .DEPTH(DEPTH), .CNT_W(4)) ifB ();
    hazard_if #(.RADDR_W(RW), .DEPTH(DEPTH), .CNT_W(8)) ifC ();

    hazard_scoreboard #(.RADDR_W(RW), .DEPTH(DEPTH), .FWD_EN(1), .RF_BYPASS(0),
                        .REDIRECT_STAGE(RS), .CNT_W(8)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
    hazard_scoreboard #(.RADDR_W(RW), .DEPTH(DEPTH), .FWD_EN(0), .RF_BYPASS(0),
                        .REDIRECT_STAGE(RS), .CNT_W(4)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));
    hazard_scoreboard #(.RADDR_W(RW), .DEPTH(DEPTH), .FWD_EN(0), .RF_BYPASS(1),
                        .REDIRECT_STAGE(RS), .CNT_W(8)) dutC (.clk(clk), .rst_n(rst_n), .bus(ifC));

    // Clock and reset
    always #5 clk = ~clk;

    int nCompared = 0;
    int nMismatched = 0;

    flight_t        flight [NDUT][$];
    int unsigned    modelCnt [NDUT];
    logic [W-1:0]   expQ [NDUT][$];

    function automatic bit cfgFwd(int d);
        return d == 0;
    endfunction

    function automatic bit cfgByp(int d);
        return d == 2;
    endfunction

    function automatic int unsigned cfgMax(int d);
        return (d == 1) ? 15 : 255;
    endfunction

    // Packed response: {0, stall, hold, bubble, flush, squash[2:0], cnt[7:0]}
    function automatic logic [W-1:0] actual(int d);
        case (d)
            0:       return {1'b0, ifA.stall_o, ifA.hold_o, ifA.bubble_o, ifA.flush_ifid_o,
                             ifA.squash_o, ifA.stall_cnt_o};
            1:       return {1'b0, ifB.stall_o, ifB.hold_o, ifB.bubble_o, ifB.flush_ifid_o,
                             ifB.squash_o, 8'(ifB.stall_cnt_o)};
            default: return {1'b0, ifC.stall_o, ifC.hold_o, ifC.bubble_o, ifC.flush_ifid_o,
                             ifC.squash_o, ifC.stall_cnt_o};
        endcase
    endfunction

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // A source depends on a writer when it is read, nonzero and names the same register.
    function automatic bit reads(bit used, logic [4:0] src, logic [4:0] rd);
        return used && (src != 5'd0) && (src == rd);
    endfunction

    // Driver: applies one ID cycle, pushes the expected response, then advances the model.
    task automatic step(bit v, logic [4:0] rs, logic [4:0] rt, bit rsu, bit rtu,
                        bit wr, logic [4:0] rd, bit ld, bit redir, bit rstn);
        @(negedge clk);
        rst_n = rstn;
        ifA.id_valid = v;  ifB.id_valid = v;  ifC.id_valid = v;
        ifA.id_rs = rs;    ifB.id_rs = rs;    ifC.id_rs = rs;
        ifA.id_rt = rt;    ifB.id_rt = rt;    ifC.id_rt = rt;
        ifA.id_rs_used = rsu; ifB.id_rs_used = rsu; ifC.id_rs_used = rsu;
        ifA.id_rt_used = rtu; ifB.id_rt_used = rtu; ifC.id_rt_used = rtu;
        ifA.id_wr = wr;    ifB.id_wr = wr;    ifC.id_wr = wr;
        ifA.id_rd = rd;    ifB.id_rd = rd;    ifC.id_rd = rd;
        ifA.id_is_load = ld; ifB.id_is_load = ld; ifC.id_is_load = ld;
        ifA.redirect_i = redir; ifB.redirect_i = redir; ifC.redirect_i = redir;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            bit hz;
            bit stall;
            bit hold;
            bit issue;
            logic [2:0] sq;
            flight_t keep [$];
            if (!rstn) begin
                flight[d].delete();
                modelCnt[d] = 0;
            end
            hz = 1'b0;
            foreach (flight[d][j]) begin
                if (reads(rsu, rs, flight[d][j].rd) || reads(rtu, rt, flight[d][j].rd)) begin
                    if (cfgFwd(d)) begin
                        if (flight[d][j].age == 0 && flight[d][j].load) hz = 1'b1;
                    end else if (flight[d][j].age < DEPTH - 1 || !cfgByp(d)) begin
                        hz = 1'b1;
                    end
                end
            end
            stall = v && hz;
            hold  = stall && !redir;
            sq    = redir ? 3'(( 1 << RS) - 1) : 3'd0;
            expQ[d].push_back({1'b0, stall, hold, redir ? 1'b1 : stall, redir, sq, 8'(modelCnt[d])});
            if (rstn) begin
                issue = v && !stall && !redir;
                keep.delete();
                foreach (flight[d][j]) begin
                    flight_t f;
                    f = flight[d][j];
                    f.age = f.age + 1;
                    if (f.age < DEPTH && !(redir && f.age >= 1 && f.age <= RS)) keep.push_back(f);
                end
                if (issue && wr && rd != 5'd0) keep.push_back('{age: 0, rd: rd, load: ld});
                flight[d] = keep;
                if (hold && modelCnt[d] < cfgMax(d)) modelCnt[d]++;
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic doReset();
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: pops one expected response per configuration each cycle.
    always @(negedge clk) begin
        logic [W-1:0] e;
        #3;
        for (int d = 0; d < NDUT; d++) begin
            if (expQ[d].size() > 0) begin
                e = expQ[d].pop_front();
                check($sformatf("cycle_dut%0d", d), actual(d), e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a;
        logic [4:0] rs, rt, rd;
        bit v, rsu, rtu, wr, ld, redir, rstn;

        doReset();
        doReset();
        #3;
        check("reset_outputs_A", actual(0), '0);

        // Load-use with forwarding: one stall cycle
        step(1, 0, 0, 0, 0, 1, 8, 1, 0, 1);
        step(1, 8, 1, 1, 1, 1, 9, 0, 0, 1);
        #3; a = actual(0); check("load_use_stall_A", W'(a[14:12]), W'(3'b111));
        step(1, 8, 1, 1, 1, 1, 9, 0, 0, 1);
        #3; a = actual(0); check("load_use_release_A", W'(a[14]), '0);
        idle();
        #3; a = actual(0); check("load_use_cnt_A", W'(a[7:0]), W'(1));

        // ALU result forwarded, and register 0 never creates a dependency
        doReset();
        step(1, 0, 0, 0, 0, 1, 8, 0, 0, 1);
        step(1, 8, 3, 1, 1, 1, 2, 0, 0, 1);
        #3; a = actual(0); check("alu_no_stall_A", W'(a[14]), '0);
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        step(1, 0, 0, 1, 1, 1, 4, 0, 0, 1);
        #3;
        for (int d = 0; d < NDUT; d++) begin
            a = actual(d);
            check($sformatf("reg0_no_stall_dut%0d", d), W'(a[14]), '0);
        end

        // No forwarding: 3 stalls without RF bypass, 2 with it
        doReset();
        step(1, 0, 0, 0, 0, 1, 8, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 8, 8, 1, 1, 0, 0, 0, 0, 1);
        idle();
        #3;
        a = actual(0); check("nofwd_cnt_A", W'(a[7:0]), W'(0));
        a = actual(1); check("nofwd_cnt_B", W'(a[7:0]), W'(3));
        a = actual(2); check("bypass_cnt_C", W'(a[7:0]), W'(2));

        // Redirect at MEM beats a pending load-use stall and squashes the younger lw
        doReset();
        step(1, 1, 2, 1, 1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1, 8, 1, 0, 1);
        step(1, 8, 8, 1, 1, 1, 9, 0, 1, 1);
        #3; a = actual(0); check("redirect_ctrl_A", W'(a[14:8]), W'(7'b1011001));
        step(1, 8, 8, 1, 1, 0, 0, 0, 0, 1);
        #3;
        a = actual(0); check("post_redirect_A", W'(a[14]), '0);
        a = actual(1); check("post_redirect_B", W'(a[14]), '0);

        // Reset mid-operation discards a tracked load
        doReset();
        step(1, 0, 0, 0, 0, 1, 8, 1, 0, 1);
        step(1, 8, 0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 8, 0, 1, 0, 0, 0, 0, 0, 1);
        #3;
        for (int d = 0; d < NDUT; d++) begin
            a = actual(d);
            check($sformatf("after_reset_dut%0d", d), W'({a[14], a[7:0]}), '0);
        end

        // Long-running hazard saturates the 4-bit counter
        doReset();
        for (int i = 0; i < 24; i++) step(1, 8, 8, 1, 1, 1, 8, 0, 0, 1);
        idle();
        #3; a = actual(1); check("cnt_saturate_B", W'(a[7:0]), W'(15));

        // Randomized traffic over a small register set to keep hazards frequent
        doReset();
        for (int i = 0; i < 400; i++) begin
            v     = ($urandom_range(0, 9) != 0);
            rs    = 5'($urandom_range(0, 3));
            rt    = 5'($urandom_range(0, 3));
            rd    = 5'($urandom_range(0, 3));
            rsu   = 1'($urandom_range(0, 1));
            rtu   = 1'($urandom_range(0, 1));
            wr    = ($urandom_range(0, 3) != 0);
            ld    = ($urandom_range(0, 2) == 0);
            redir = ($urandom_range(0, 7) == 0);
            rstn  = ($urandom_range(0, 59) != 0);
            step(v, rs, rt, rsu, rtu, wr, rd, ld, redir, rstn);
        end
        idle();

        @(negedge clk);
        #5;
        for (int d = 0; d < NDUT; d++)
            check($sformatf("queue_drain_dut%0d", d), W'(expQ[d].size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
